// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: takes one parallel word over valid/ready and sequences the
// PISO left-shift register (hold/load/shift/clear) so the word leaves MSB
// first, one bit every ClkDiv clocks, framed by cs_no and a done pulse.
module piso_tx_ctrl #(
  parameter int unsigned Width  = 8,
  parameter int unsigned ClkDiv = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             ready_o,
  input  logic             abort_i,
  output logic [Width-1:0] pdata_o,
  output logic [1:0]       op_o,
  output logic             cs_no,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int unsigned BitW = (Width > 1) ? $clog2(Width) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(Width - 1);

  localparam logic [1:0] OpHold  = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpShift = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [DivW-1:0] div_cnt_q;
  logic [BitW-1:0] bit_cnt_q;
  logic            div_last;
  logic            bit_last;

  assign div_last = (div_cnt_q == DivLast);
  assign bit_last = (bit_cnt_q == BitLast);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Word buffer and bit-rate / bit-position counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pdata_o   <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            pdata_o <= data_i;
          end
        end
        LOAD: begin
          div_cnt_q <= '0;
          bit_cnt_q <= '0;
        end
        SHIFT: begin
          if (div_last) begin
            div_cnt_q <= '0;
            if (!bit_last) begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end else begin
            div_cnt_q <= div_cnt_q + DivW'(1);
          end
        end
        default: begin
          div_cnt_q <= div_cnt_q;
        end
      endcase
    end
  end

  // Next-state decode; abort wins over every other exit from LOAD/SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = abort_i ? ABORT : SHIFT;
      end
      SHIFT: begin
        if (abort_i) begin
          state_d = ABORT;
        end else if (div_last && bit_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from state and counters only.
  always_comb begin
    ready_o = 1'b0;
    op_o    = OpHold;
    cs_no   = 1'b1;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
      end
      LOAD: begin
        op_o   = OpLoad;
        busy_o = 1'b1;
      end
      SHIFT: begin
        cs_no  = 1'b0;
        busy_o = 1'b1;
        // The last bit is only held for its period; no shift after it.
        if (div_last && !bit_last) begin
          op_o = OpShift;
        end
      end
      DONE: begin
        done_o = 1'b1;
      end
      ABORT: begin
        op_o = OpClear;
      end
      default: begin
        op_o = OpHold;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: two instances (8-bit/div 4 and 4-bit/div 1), a
// phase-count reference model, a model of the downstream shift register,
// directed scenarios with literal expectations, then random traffic.
module tb_piso_tx_ctrl;

  localparam int WA = 8;
  localparam int CA = 4;
  localparam int WB = 4;
  localparam int CB = 1;

  logic clk = 1'b0;
  logic rst_n;

  logic          valid_a, abort_a, ready_a, cs_a, busy_a, done_a;
  logic [WA-1:0] data_a, pdata_a;
  logic [1:0]    op_a;

  logic          valid_b, abort_b, ready_b, cs_b, busy_b, done_b;
  logic [WB-1:0] data_b, pdata_b;
  logic [1:0]    op_b;

  int checks   = 0;
  int failures = 0;

  // Reference model: ph = 0 idle, 1 load, 2..1+W*C serial cycles,
  // 2+W*C done, -1 abort cycle.
  int            ph_a, ph_b;
  logic [WA-1:0] word_a;
  logic [WB-1:0] word_b;

  // Downstream shift-register model fed by the DUT outputs.
  logic [WA-1:0] sr_a, pd_a_s;
  logic [WB-1:0] sr_b, pd_b_s;
  logic [1:0]    op_a_s, op_b_s;

  logic [1:0] rec_op   [0:39];
  logic       rec_cs   [0:39];
  logic       rec_q    [0:39];
  logic       rec_done [0:39];

  always #5 clk = ~clk;

  piso_tx_ctrl #(.Width(WA), .ClkDiv(CA)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_a), .data_i(data_a),
    .ready_o(ready_a), .abort_i(abort_a), .pdata_o(pdata_a), .op_o(op_a),
    .cs_no(cs_a), .busy_o(busy_a), .done_o(done_a)
  );

  piso_tx_ctrl #(.Width(WB), .ClkDiv(CB)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_b), .data_i(data_b),
    .ready_o(ready_b), .abort_i(abort_b), .pdata_o(pdata_b), .op_o(op_b),
    .cs_no(cs_b), .busy_o(busy_b), .done_o(done_b)
  );

  function automatic int next_ph(int ph, int w, int c, logic v, logic ab);
    if (ph == 0) return v ? 1 : 0;
    if (ph < 0 || ph == 2 + w * c) return 0;
    return ab ? -1 : ph + 1;
  endfunction

  // {ready, op[1:0], cs_n, busy, done}
  function automatic logic [5:0] exp_ctl(int ph, int w, int c);
    int s;
    if (ph == 0) return 6'b1_00_1_0_0;
    if (ph < 0) return 6'b0_11_1_0_0;
    if (ph == 1) return 6'b0_01_1_1_0;
    if (ph == 2 + w * c) return 6'b0_00_1_0_1;
    s = ph - 2;
    if ((s % c == c - 1) && (s / c < w - 1)) return 6'b0_10_0_1_0;
    return 6'b0_00_0_1_0;
  endfunction

  function automatic bit in_shift(int ph, int w, int c);
    return (ph >= 2) && (ph <= 1 + w * c);
  endfunction

  // Model update on the same edges the DUT sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_a   <= 0;
      ph_b   <= 0;
      word_a <= '0;
      word_b <= '0;
    end else begin
      if (ph_a == 0 && valid_a) word_a <= data_a;
      if (ph_b == 0 && valid_b) word_b <= data_b;
      ph_a <= next_ph(ph_a, WA, CA, valid_a, abort_a);
      ph_b <= next_ph(ph_b, WB, CB, valid_b, abort_b);
    end
  end

  // Capture op/data mid-cycle so the register model applies them on the next edge.
  always @(negedge clk) begin
    op_a_s <= op_a;
    pd_a_s <= pdata_a;
    op_b_s <= op_b;
    pd_b_s <= pdata_b;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_a <= '0;
      sr_b <= '0;
    end else begin
      case (op_a_s)
        2'b01:   sr_a <= pd_a_s;
        2'b10:   sr_a <= {sr_a[WA-2:0], 1'b0};
        2'b11:   sr_a <= '0;
        default: sr_a <= sr_a;
      endcase
      case (op_b_s)
        2'b01:   sr_b <= pd_b_s;
        2'b10:   sr_b <= {sr_b[WB-2:0], 1'b0};
        2'b11:   sr_b <= '0;
        default: sr_b <= sr_b;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int idx;
    chk("ctl_a", 32'({ready_a, op_a, cs_a, busy_a, done_a, pdata_a}),
        32'({exp_ctl(ph_a, WA, CA), word_a}));
    chk("ctl_b", 32'({ready_b, op_b, cs_b, busy_b, done_b, pdata_b}),
        32'({exp_ctl(ph_b, WB, CB), word_b}));
    if (in_shift(ph_a, WA, CA)) begin
      idx = WA - 1 - (ph_a - 2) / CA;
      chk("q_a", 32'(sr_a[WA-1]), 32'(word_a[idx[2:0]]));
    end
    if (in_shift(ph_b, WB, CB)) begin
      idx = WB - 1 - (ph_b - 2) / CB;
      chk("q_b", 32'(sr_b[WB-1]), 32'(word_b[idx[1:0]]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int k;
    int cnt;
    int done_edge;
    logic [7:0] qbits;
    logic [3:0] qb4;

    rst_n   = 1'b0;
    valid_a = 1'b0; data_a = '0; abort_a = 1'b0;
    valid_b = 1'b0; data_b = '0; abort_b = 1'b0;
    tick();
    tick();
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_cs_a", 32'(cs_a), 32'd1);
    chk("rst_pdata_a", 32'(pdata_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single 8'hA5 frame, valid dropped after the accept.
    valid_a = 1'b1; data_a = 8'hA5;
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 36; i++) begin
      rec_op[i] = op_a; rec_cs[i] = cs_a; rec_q[i] = sr_a[WA-1]; rec_done[i] = done_a;
      data_a = 8'($urandom);
      tick();
    end
    chk("a5_op_load", 32'(rec_op[0]), 32'd1);
    for (int r = 0; r < 7; r++) begin
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("a5_op_%0d", 1 + 4 * r + m), 32'(rec_op[1 + 4 * r + m]),
            (m == 3) ? 32'd2 : 32'd0);
      end
    end
    for (int m = 29; m < 34; m++) chk($sformatf("a5_op_%0d", m), 32'(rec_op[m]), 32'd0);
    qbits = 8'b1010_0101;
    for (int j = 0; j < 8; j++) begin
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("a5_q_bit%0d_%0d", j, m), 32'(rec_q[1 + 4 * j + m]), 32'(qbits[7 - j]));
      end
    end
    cnt = 0;
    done_edge = -1;
    for (int i = 0; i < 36; i++) begin
      if (!rec_cs[i]) cnt++;
      if (rec_done[i] && done_edge < 0) done_edge = i + 1;
    end
    chk("a5_cs_low_cycles", 32'(cnt), 32'd32);
    chk("a5_done_edge", 32'(done_edge), 32'd34);

    // Back-to-back: valid held high, data churns during the frame.
    valid_a = 1'b1; data_a = 8'h3C;
    tick();
    cnt = 0;
    while (ready_a == 1'b0 && cnt < 100) begin
      cnt++;
      data_a = (cnt >= 30) ? 8'hC3 : 8'($urandom);
      tick();
    end
    chk("b2b_ready_low", 32'(cnt), 32'd34);
    chk("b2b_hold_first", 32'(pdata_a), 32'h3C);
    tick();
    chk("b2b_second_word", 32'(pdata_a), 32'hC3);
    chk("b2b_second_busy", 32'(busy_a), 32'd1);
    valid_a = 1'b0;
    repeat (40) tick();

    // Abort during bit 3 of an 8'hFF frame.
    valid_a = 1'b1; data_a = 8'hFF;
    tick();
    valid_a = 1'b0;
    repeat (13) tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_op", 32'(op_a), 32'd3);
    chk("abort_cs", 32'(cs_a), 32'd1);
    chk("abort_done", 32'(done_a), 32'd0);
    tick();
    chk("abort_ready", 32'(ready_a), 32'd1);
    chk("abort_no_done", 32'(done_a), 32'd0);
    repeat (3) tick();

    // ClkDiv = 1, Width = 4, word 4'b1001.
    valid_b = 1'b1; data_b = 4'b1001;
    tick();
    valid_b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rec_op[i] = op_b; rec_cs[i] = cs_b; rec_q[i] = sr_b[WB-1]; rec_done[i] = done_b;
      tick();
    end
    qb4 = 4'b1001;
    chk("d1_op_load", 32'(rec_op[0]), 32'd1);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("d1_cs_%0d", i), 32'(rec_cs[i]), 32'd0);
      chk($sformatf("d1_op_%0d", i), 32'(rec_op[i]), (i < 4) ? 32'd2 : 32'd0);
      chk($sformatf("d1_q_%0d", i), 32'(rec_q[i]), 32'(qb4[4 - i]));
    end
    chk("d1_cs_after", 32'(rec_cs[5]), 32'd1);
    chk("d1_done", 32'(rec_done[5]), 32'd1);

    // Reset in the middle of a serial frame.
    valid_a = 1'b1; data_a = 8'h5A;
    tick();
    valid_a = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_op", 32'(op_a), 32'd0);
    chk("mrst_cs", 32'(cs_a), 32'd1);
    chk("mrst_busy", 32'(busy_a), 32'd0);
    chk("mrst_done", 32'(done_a), 32'd0);
    chk("mrst_pdata", 32'(pdata_a), 32'd0);
    chk("mrst_ready", 32'(ready_a), 32'd1);
    compare_all();
    tick();
    rst_n = 1'b1;
    tick();
    valid_a = 1'b1; data_a = 8'h81;
    tick();
    valid_a = 1'b0;
    done_edge = -1;
    for (k = 0; k < 40 && done_edge < 0; k++) begin
      if (done_a) done_edge = k + 1;
      else tick();
    end
    chk("mrst_done_edge", 32'(done_edge), 32'd34);
    chk("mrst_word", 32'(pdata_a), 32'h81);

    // Random traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      valid_a = 1'($urandom_range(0, 1));
      data_a  = 8'($urandom);
      abort_a = ($urandom_range(0, 31) == 0);
      valid_b = 1'($urandom_range(0, 1));
      data_b  = 4'($urandom);
      abort_b = ($urandom_range(0, 15) == 0);
      tick();
    end
    valid_a = 1'b0; abort_a = 1'b0;
    valid_b = 1'b0; abort_b = 1'b0;
    repeat (50) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_tx_ctrl.md
Name: piso_tx_ctrl

Overview:
- Sequencer that drives the team's parallel-in/serial-out left-shift register.
- Accepts a parallel word over a valid/ready handshake and buffers it.
- Issues the register's 2-bit op code (00 hold, 01 load, 10 shift left, 11 clear) so the word leaves MSB first at a programmable bit rate.
- Frames the transfer with an active-low select and a done pulse. It sits between a word producer and the shift register's d_i/op_i inputs.

Parameters:
- Width, 8, word length in bits; must be >= 2.
- ClkDiv, 4, clk_i cycles per serial bit; must be >= 1.

Ports:
- clk_i  input  1  system clock; the only clock.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  producer has a word on data_i.
- data_i  input  Width  parallel word to transmit.
- ready_o  output  1  controller can accept a word.
- abort_i  input  1  cancel the frame in progress.
- pdata_o  output  Width  buffered word; connects to the register's d_i.
- op_o  output  2  op code; connects to the register's op_i.
- cs_no  output  1  active-low frame select.
- busy_o  output  1  frame in progress.
- done_o  output  1  one-cycle pulse when a frame completes normally.

Behaviour:
- One clock (clk_i). Reset is asynchronous and active-low (rst_ni).
- Reset forces:
  - state IDLE; div_cnt, bit_cnt, pdata_o = 0;
  - op_o = 00, cs_no = 1, busy_o = 0, done_o = 0;
  - ready_o follows IDLE, i.e. 1.
- All outputs are Moore-decoded from registered state and counters. There is no combinational path from any input to any output.
- Counter widths: $clog2(ClkDiv) for div_cnt and $clog2(Width) for bit_cnt, each at least 1 bit.
- States and outputs:
  - IDLE: ready_o = 1, op_o = 00, cs_no = 1. On valid_i = 1, capture data_i into pdata_o and go to LOAD.
  - LOAD (1 cycle): op_o = 01, busy_o = 1, cs_no = 1. Clear both counters; go to SHIFT. The register loads pdata_o on this edge.
  - SHIFT: cs_no = 0, busy_o = 1.
    - div_cnt counts 0..ClkDiv-1 and wraps.
    - At div_cnt = ClkDiv-1 with bit_cnt < Width-1: op_o = 10 for that cycle and bit_cnt increments. Otherwise op_o = 00.
    - At div_cnt = ClkDiv-1 with bit_cnt = Width-1: go to DONE, with no final shift.
  - DONE (1 cycle): done_o = 1, cs_no = 1, busy_o = 0, op_o = 00. Go to IDLE.
  - ABORT (1 cycle): op_o = 11, cs_no = 1, busy_o = 0, done_o = 0. Go to IDLE.
- Timing:
  - The register's q_o carries bit Width-1-k during bit period k.
  - Each bit period is exactly ClkDiv cycles of cs_no = 0.
  - Total cs_no-low time is Width*ClkDiv cycles.
  - From the accept edge to the done_o pulse: 2 + Width*ClkDiv cycles.
- Handshake:
  - A word transfers on a clock edge with valid_i = 1 and ready_o = 1.
  - data_i is sampled only on that edge. The producer may change it afterwards.
  - valid_i is ignored outside IDLE. No second buffer exists.
- Back-to-back words: a new word may be accepted on the first IDLE cycle after DONE. The minimum frame period is therefore 3 + Width*ClkDiv cycles.
- ClkDiv = 1: op_o = 10 on every SHIFT cycle except the last.
- abort_i:
  - Sampled in LOAD and SHIFT; it takes priority over every other transition there.
  - It moves the controller to ABORT on the next edge.
  - In IDLE and DONE it has no effect.
- Asserting rst_ni low mid-frame immediately forces the reset values above, with no DONE pulse. After rst_ni releases, the controller sits in IDLE.
- pdata_o holds its value until the next accept.

Test Plan:
- Width=8, ClkDiv=4; accept 8'hA5, then hold valid_i low:
  - op_o sequence is 01, then 00,00,00,10 repeated 7 times, then 00,00,00,00;
  - q_o bits during cs_no low are 1,0,1,0,0,1,0,1, each 4 cycles;
  - done_o pulses 34 cycles after the accept edge.
- valid_i held high with words 8'h3C then 8'hC3:
  - the second accept occurs on the first IDLE cycle after DONE;
  - ready_o is low for 34 cycles in between;
  - data_i changes during the frame are ignored.
- Assert abort_i for one cycle at bit 3 of an 8'hFF frame:
  - next cycle op_o = 11, cs_no = 1, no done_o;
  - following cycle ready_o = 1.
- ClkDiv=1, Width=4, word 4'b1001:
  - cs_no low for 4 cycles;
  - op_o = 10 on the first three of them;
  - q_o = 1,0,0,1.
- Pull rst_ni low mid-SHIFT:
  - outputs immediately go to op_o = 00, cs_no = 1, busy_o = 0, done_o = 0, pdata_o = 0;
  - after release, a new 8'h81 frame completes normally.
